// File: rtl/shift_reg_rs_pkg.sv
// Shared definitions for the shift_reg_rs block: mode encodings and the cnt width helper.
package shift_reg_rs_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    // Width of the shift counter; never less than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/shift_reg_next.sv
// Combinational next-value mux for the shift register contents.
// With SHIFT_REG_RS_ROTATE_EN defined, rot=1 recirculates the shifted-out bit.
module shift_reg_next
    import shift_reg_rs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] q_cur,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             rot,
    output logic [WIDTH-1:0] q_nxt
);

    logic fill_lsb;
    logic fill_msb;

`ifdef SHIFT_REG_RS_ROTATE_EN
    assign fill_lsb = rot ? q_cur[WIDTH-1] : sin_r;
    assign fill_msb = rot ? q_cur[0]       : sin_l;
`else
    logic rot_unused;
    assign rot_unused = rot;
    assign fill_lsb   = sin_r;
    assign fill_msb   = sin_l;
`endif

    always_comb begin
        q_nxt = q_cur;
        if (en) begin
            case (mode)
                MODE_HOLD: q_nxt = q_cur;
                MODE_LOAD: q_nxt = d;
                MODE_SHL:  q_nxt = {q_cur[WIDTH-2:0], fill_lsb};
                MODE_SHR:  q_nxt = {fill_msb, q_cur[WIDTH-1:1]};
                default:   q_nxt = q_cur;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_rs.sv
// Loadable left/right shift register with set/reset, shift counter and wrap pulse.
// Optional rotate feature enabled by defining SHIFT_REG_RS_ROTATE_EN.
module shift_reg_rs
    import shift_reg_rs_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          set,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              d,
    input  logic                          sin_r,
    input  logic                          sin_l,
    input  logic                          rot,
    output logic [WIDTH-1:0]              q,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          wrap
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d, q_sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    shift_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .en    (en),
        .mode  (mode),
        .q_cur (q_q),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .rot   (rot),
        .q_nxt (q_sel)
    );

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (set) begin
            q_d   = SET_VAL;
            cnt_d = '0;
        end else if (en) begin
            q_d = q_sel;
            case (mode)
                MODE_LOAD: cnt_d = '0;
                MODE_SHL, MODE_SHR: begin
                    // Both directions share one counter; it wraps after WIDTH shifts.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_shift_reg_rs.sv
// Directed, table-driven bench for shift_reg_rs (WIDTH=8, RESET_VAL=0, SET_VAL=FF).
module tb_shift_reg_rs;
    import shift_reg_rs_pkg::*;

    logic       clk = 1'b0;
    logic       reset, set, en, sin_r, sin_l, rot;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic [2:0] cnt;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_reg_rs #(
        .WIDTH     (8),
        .RESET_VAL (8'h00),
        .SET_VAL   (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .rot   (rot),
        .q     (q),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    typedef struct {
        string      name;
        logic       reset;
        logic       set;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin_r;
        logic       sin_l;
        logic       rot;
        logic [7:0] exp_q;
        logic [2:0] exp_cnt;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic r, input logic s, input logic e,
                       input logic [1:0] m, input logic [7:0] dd, input logic sr,
                       input logic sl, input logic ro, input logic [7:0] eq,
                       input logic [2:0] ec, input logic ew);
        vec_t v;
        v.name = name; v.reset = r; v.set = s; v.en = e; v.mode = m; v.d = dd;
        v.sin_r = sr; v.sin_l = sl; v.rot = ro;
        v.exp_q = eq; v.exp_cnt = ec; v.exp_wrap = ew;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic e, input logic [1:0] m,
                         input logic [7:0] dd, input logic sr, input logic sl, input logic ro);
        reset = r; set = s; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl; rot = ro;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eq, input logic [2:0] ec,
                         input logic ew);
        checks += 3;
        if (q !== eq) begin
            failures++;
            $display("FAIL %s q: got %h expected %h", name, q, eq);
        end
        if (cnt !== ec) begin
            failures++;
            $display("FAIL %s cnt: got %0d expected %0d", name, cnt, ec);
        end
        if (wrap !== ew) begin
            failures++;
            $display("FAIL %s wrap: got %b expected %b", name, wrap, ew);
        end
        $display("txn %-14s q=%h cnt=%0d wrap=%b", name, q, cnt, wrap);
    endtask

    initial begin
        logic [7:0] exp_rot_l, exp_rot_r;
        logic [7:0] sh;

        //    name            rst set en mode       d      sr sl ro   q      cnt wrap
        add("reset_prio",     1, 1, 1, MODE_LOAD, 8'hA5, 1, 1, 1, 8'h00, 0, 0);
        add("set",            0, 1, 1, MODE_LOAD, 8'h11, 0, 0, 0, 8'hFF, 0, 0);
        add("load_3c",        0, 0, 1, MODE_LOAD, 8'h3C, 0, 0, 0, 8'h3C, 0, 0);
        add("hold_mode00",    0, 0, 1, MODE_HOLD, 8'h55, 1, 1, 1, 8'h3C, 0, 0);
        add("hold_en0",       0, 0, 0, MODE_LOAD, 8'h99, 1, 1, 1, 8'h3C, 0, 0);
        add("load_81",        0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 0, 0);
        add("shl_1",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h02, 1, 0);
        add("shl_2",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h04, 2, 0);
        add("shl_3",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h08, 3, 0);
        add("shl_4",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h10, 4, 0);
        add("shl_5",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h20, 5, 0);
        add("shl_6",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h40, 6, 0);
        add("shl_7",          0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h80, 7, 0);
        add("shl_8_wrap",     0, 0, 1, MODE_SHL,  8'hFF, 0, 1, 0, 8'h00, 0, 1);
        add("post_wrap_hold", 0, 0, 1, MODE_HOLD, 8'hFF, 1, 1, 0, 8'h00, 0, 0);
        add("load_81b",       0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 0, 0);
        add("shr_en1_a",      0, 0, 1, MODE_SHR,  8'h00, 0, 1, 0, 8'hC0, 1, 0);
        add("shr_en0_a",      0, 0, 0, MODE_SHR,  8'h00, 1, 0, 0, 8'hC0, 1, 0);
        add("shr_en1_b",      0, 0, 1, MODE_SHR,  8'h00, 0, 1, 0, 8'hE0, 2, 0);
        add("shr_en0_b",      0, 0, 0, MODE_SHR,  8'h00, 1, 0, 0, 8'hE0, 2, 0);
        add("shr_en1_c",      0, 0, 1, MODE_SHR,  8'h00, 0, 1, 0, 8'hF0, 3, 0);
        add("shr_en0_c",      0, 0, 0, MODE_SHR,  8'h00, 1, 0, 0, 8'hF0, 3, 0);
        add("dir_change_l",   0, 0, 1, MODE_SHL,  8'h00, 1, 0, 0, 8'hE1, 4, 0);
        add("dir_change_r",   0, 0, 1, MODE_SHR,  8'hFF, 1, 0, 0, 8'h70, 5, 0);
        add("set_over_shift", 0, 1, 1, MODE_SHL,  8'h00, 0, 0, 0, 8'hFF, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].reset, tbl[i].set, tbl[i].en, tbl[i].mode, tbl[i].d,
                  tbl[i].sin_r, tbl[i].sin_l, tbl[i].rot);
            check(tbl[i].name, tbl[i].exp_q, tbl[i].exp_cnt, tbl[i].exp_wrap);
        end

`ifdef SHIFT_REG_RS_ROTATE_EN
        exp_rot_l = 8'h03;
        exp_rot_r = 8'hC0;
`else
        exp_rot_l = 8'h02;
        exp_rot_r = 8'h40;
`endif
        // Rotate select, left then right, with serial inputs held at 0.
        drive(0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 0);
        check("rot_load", 8'h81, 0, 0);
        drive(0, 0, 1, MODE_SHL, 8'h00, 0, 0, 1);
        check("rot_left", exp_rot_l, 1, 0);
        drive(0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 0);
        drive(0, 0, 1, MODE_SHR, 8'h00, 0, 0, 1);
        check("rot_right", exp_rot_r, 1, 0);

        // Five shifts, reset mid-sequence, then one more shift restarts the count.
        drive(0, 0, 1, MODE_LOAD, 8'h01, 0, 0, 0);
        sh = 8'h01;
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, MODE_SHL, 8'h00, 1, 0, 0);
            sh = {sh[6:0], 1'b1};
        end
        check("five_shifts", sh, 5, 0);
        drive(1, 0, 1, MODE_SHL, 8'h00, 1, 0, 0);
        check("mid_reset", 8'h00, 0, 0);
        drive(0, 0, 1, MODE_SHL, 8'h00, 1, 0, 0);
        check("after_reset", 8'h01, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
